// File: rtl/parity_arb_sched_pkg.sv
// rtl/parity_arb_sched_pkg.sv - shared FSM encoding and defaults for the parity arbiter
package parity_arb_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int DEF_DW = 8;

endpackage

// File: rtl/parity_arb_sched_if.sv
// rtl/parity_arb_sched_if.sv - requester and result handshake bundle for parity_arb_sched
interface parity_arb_sched_if
    import parity_arb_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DEF_DW
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic               res_ready;
    logic [IDW-1:0]     res_id;
    logic [DW-1:0]      res_data;
    logic               res_pe;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_data, res_pe
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_data, res_pe
    );

endinterface

// File: rtl/parity_core.sv
// rtl/parity_core.sv - combinational XOR-reduction parity checker
module parity_core #(
    parameter int DW         = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [DW-1:0] data,
    output logic          pe
);

    // Odd scheme flags a word whose ones-count is even.
    assign pe = PARITY_ODD ? ~^data : ^data;

endmodule

// File: rtl/parity_arb_sched.sv
// rtl/parity_arb_sched.sv - round-robin arbiter sharing one parity checker, with error counters
module parity_arb_sched
    import parity_arb_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = DEF_DW,
    parameter int CNT_W      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_arb_sched_if.slave     bus,
    output logic                  busy,
    input  logic                  clr_cnt,
    output logic [NREQ*CNT_W-1:0] err_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [DW-1:0]    gnt_data;
    logic [DW-1:0]    cap_data_q;
    logic [IDW-1:0]   cap_id_q;
    logic             res_valid_q;
    logic             res_pe_q;
    logic             pe;
    logic             xfer;
    logic             accept;
    logic [CNT_W-1:0] cnt_q [NREQ];

    // First valid requester after the last winner, wrapping modulo NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  last);
        logic [NREQ-1:0] g;
        int              idx;
        g = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (g == '0 && valid[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        gnt      = rr_pick(bus.req_valid, last_q);
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = IDW'(i);
                gnt_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = gnt;
                if (|gnt) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_HOLD;
            S_HOLD: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign xfer   = (state_q == S_IDLE) && (|gnt);
    assign accept = res_valid_q && bus.res_ready;

    parity_core #(
        .DW         (DW),
        .PARITY_ODD (PARITY_ODD)
    ) u_core (
        .data (cap_data_q),
        .pe   (pe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= IDW'(NREQ - 1);
            cap_data_q  <= '0;
            cap_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                cap_data_q <= gnt_data;
                cap_id_q   <= gnt_idx;
                last_q     <= gnt_idx;
            end
            if (state_q == S_CHECK) begin
                res_valid_q <= 1'b1;
                res_pe_q    <= pe;
            end else if (accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || clr_cnt) begin
                cnt_q[i] <= '0;
            end else if (accept && res_pe_q && cap_id_q == IDW'(i) && cnt_q[i] != CNT_MAX) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
        assign err_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = cap_id_q;
    assign bus.res_data  = cap_data_q;
    assign bus.res_pe    = res_pe_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_arb_sched.sv
// tb/tb_parity_arb_sched.sv - directed self-checking bench for parity_arb_sched
module tb_parity_arb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic        busy, busy_o;
    logic [31:0] err_cnt, err_cnt_o;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    parity_arb_sched_if #(.NREQ(4), .DW(8)) bus ();
    parity_arb_sched_if #(.NREQ(4), .DW(8)) bus_o ();

    assign bus_o.req_valid = bus.req_valid;
    assign bus_o.req_data  = bus.req_data;
    assign bus_o.res_ready = bus.res_ready;

    parity_arb_sched #(.NREQ(4), .DW(8), .CNT_W(8), .PARITY_ODD(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .clr_cnt (clr_cnt),
        .err_cnt (err_cnt)
    );

    parity_arb_sched #(.NREQ(4), .DW(8), .CNT_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_o),
        .busy    (busy_o),
        .clr_cnt (clr_cnt),
        .err_cnt (err_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int prev;
        int k;
        int n;
        logic [7:0] words [4];

        rst           = 1'b1;
        clr_cnt       = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // 1: reset state, single even-parity word, latency T+2
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'b11101110};
        #1 chk("t1_req_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0000;
        chk("t1_check_valid", bus.res_valid, 0);
        chk("t1_check_busy", busy, 1);
        chk("t1_check_ready", bus.req_ready, 0);
        tick();
        chk("t1_hold_valid", bus.res_valid, 1);
        chk("t1_hold_id", bus.res_id, 0);
        chk("t1_hold_data", bus.res_data, 8'hEE);
        chk("t1_hold_pe", bus.res_pe, 0);
        chk("t1_odd_pe", bus_o.res_pe, 1);
        bus.res_ready = 1'b1;
        tick();
        chk("t1_idle_valid", bus.res_valid, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // 2: odd-ones word from requester 1
        bus.req_valid = 4'b0010;
        bus.req_data  = {8'h00, 8'h00, 8'b11111000, 8'h00};
        #1 chk("t2_req_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        chk("t2_hold_id", bus.res_id, 1);
        chk("t2_hold_pe", bus.res_pe, 1);
        chk("t2_odd_pe", bus_o.res_pe, 0);
        tick();
        chk("t2_err_cnt", err_cnt, 32'h0000_0100);
        chk("t2_odd_err_cnt", err_cnt_o, 32'h0000_0001);

        // move pointer to 3 so the all-request run starts at 0
        bus.req_valid = 4'b1000;
        bus.req_data  = {8'h0F, 8'h00, 8'h00, 8'h00};
        #1 chk("t3_pre_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'b0000;
        repeat (2) tick();

        // 3: all requesting, 8 results
        words = '{8'h01, 8'h03, 8'h07, 8'h0F};
        bus.req_data  = {words[3], words[2], words[1], words[0]};
        bus.req_valid = 4'b1111;
        cyc = 0;
        prev = 0;
        k = 0;
        while (cyc < 60 && k < 8) begin
            tick();
            cyc++;
            if (bus.res_valid) begin
                chk("t3_id", bus.res_id, k % 4);
                chk("t3_data", bus.res_data, words[k % 4]);
                if (k == 0) chk("t3_first_lat", cyc, 2);
                else chk("t3_spacing", cyc - prev, 3);
                prev = cyc;
                k++;
                if (k == 8) bus.req_valid = 4'b0000;
            end
        end
        chk("t3_result_count", k, 8);
        tick();
        chk("t3_err_cnt", err_cnt, 32'h0002_0102);

        // 4: stall in HOLD
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h00, 8'h55, 8'h00, 8'h00};
        #1 chk("t4_req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", bus.res_valid, 1);
            chk("t4_id", bus.res_id, 2);
            chk("t4_data", bus.res_data, 8'h55);
            chk("t4_pe", bus.res_pe, 0);
            chk("t4_ready_zero", bus.req_ready, 0);
            tick();
        end
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0000;
        tick();
        chk("t4_release_busy", busy, 0);
        chk("t4_release_valid", bus.res_valid, 0);

        // 5: saturation of counter 2
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h00, 8'hA8, 8'h00, 8'h00};
        n = 0;
        cyc = 0;
        while (cyc < 1000 && n < 260) begin
            tick();
            cyc++;
            if (bus.res_valid) begin
                n++;
                if (n == 253) chk("t5_cnt_254", err_cnt[23:16], 254);
                if (n == 254) chk("t5_cnt_255", err_cnt[23:16], 255);
                if (n == 260) begin
                    chk("t5_cnt_sat", err_cnt[23:16], 255);
                    bus.req_valid = 4'b0000;
                end
            end
        end
        chk("t5_result_count", n, 260);
        tick();
        chk("t5_err_cnt", err_cnt, 32'h00FF_0102);

        // clear coinciding with an accepted error result
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        chk("t5_clr_hold", bus.res_valid & bus.res_pe, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("t5_clr_wins", err_cnt, 0);

        // 6: reset while holding a result
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h01};
        tick();
        bus.req_valid = 4'b0000;
        repeat (2) tick();
        chk("t6_pre_cnt", err_cnt, 32'h0000_0001);
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1111;
        #1 chk("t6_ready_ptr", bus.req_ready, 4'b0010);
        repeat (2) tick();
        chk("t6_hold_valid", bus.res_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", bus.res_valid, 0);
        chk("t6_rst_cnt", err_cnt, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_data", bus.res_data, 0);
        chk("t6_rst_grant", bus.req_ready, 4'b0001);
        bus.req_valid = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
